imem_banked: RTL and testbench
==============================

IMEM_BANKED -- requirements
Module: imem_banked

Interface
REQ-001 Parameter PC_BITWIDTH, default 16: byte-address width; memory size 2^PC_BITWIDTH bytes.
REQ-002 Parameter NUM_BANKS, default 4: byte-wide banks; power of two, 2..8.
REQ-003 Parameter FETCH_BYTES, default 3: bytes returned per fetch; 1..NUM_BANKS.
REQ-004 Derived: LB = log2(NUM_BANKS); ROW_BITS = PC_BITWIDTH-LB; FW = 8*FETCH_BYTES; WW = 8*NUM_BANKS.
REQ-005 Clocking: reset reset_n, asynchronous, active-low; clock clk.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset_n  in  1  async active-low reset.
REQ-008 we  in  1  write strobe, row-aligned.
REQ-009 wr_addr  in  ROW_BITS  write row address.
REQ-010 wr_data  in  WW  write data; bits [WW-1-8i -: 8] target bank i.
REQ-011 wr_be  in  NUM_BANKS  byte enables; bit i gates bank i.
REQ-012 re_A  in  1  fetch request, port A.
REQ-013 addr_A  in  PC_BITWIDTH  fetch byte address, any alignment.
REQ-014 re_B  in  1  fetch request, port B; accepted only when rdy_B=1.
REQ-015 addr_B  in  PC_BITWIDTH  fetch byte address, port B.
REQ-016 rdy_B  out  1  port B can accept a request.
REQ-017 valid_A / valid_B  out  1 each  fetch result valid.
REQ-018 instr_A / instr_B  out  FW each  fetched bytes; byte at addr in MSBs.
REQ-019 row_data_B  out  WW  full row read by port B, bank 0 in MSBs.

Function
REQ-020 Byte address a maps to bank a mod NUM_BANKS, row a >> LB.
REQ-021 Fetch at address a: byte k (0..FETCH_BYTES-1) = mem[(a+k) mod 2^PC_BITWIDTH]; bank i row = (a>>LB) + (i < a[LB-1:0] ? 1 : 0), modulo 2^ROW_BITS.
REQ-022 instr_X[FW-1-8k -: 8] = byte k; reorder driven by registered low address bits of the issued request.
REQ-023 Read latency exactly 1 cycle: request issued in cycle n -> valid_X=1 and data in cycle n+1; valid_X=0 in cycles with no issued request.
REQ-024 instr_X and row_data_B hold their last value while valid_X=0.
REQ-025 Port A is read-only and never stalls; every re_A is issued in the same cycle.
REQ-026 Port B shares bank port with writes; writes have priority.
REQ-027 Port B FSM states IDLE, PEND; reset state IDLE; rdy_B = (state==IDLE).
REQ-028 IDLE, re_B=1, we=0: issue read, stay IDLE.
REQ-029 IDLE, re_B=1, we=1: perform write, capture addr_B into pending register, go PEND.
REQ-030 PEND, we=1: perform write, hold pending address, stay PEND.
REQ-031 PEND, we=0: issue pending read, go IDLE; re_B ignored this cycle (rdy_B=0).
REQ-032 Write updates bank i at row wr_addr only where wr_be[i]=1; other bytes unchanged.
REQ-033 Read same cycle as write to same location (either port) returns old data; read in the following cycle returns new data.
REQ-034 row_data_B = all NUM_BANKS banks at row addr_B>>LB (unincremented), updated with valid_B.
REQ-035 Fetch wrap past address 2^PC_BITWIDTH-1 continues at row 0 with no error flag.

Reset
REQ-036 Reset asserted: state=IDLE, rdy_B=1, valid_A=valid_B=0, instr_A=instr_B=0, row_data_B=0, pending address=0, within the same cycle (async).
REQ-037 Memory contents are not cleared by reset.
REQ-038 Reset mid-PEND discards the pending read; no valid_B after release.
REQ-039 First request accepted on the first rising edge with reset_n=1.

Verification (defaults: NUM_BANKS=4, FETCH_BYTES=3)
REQ-040 Write rows 0,1 = 0x00112233, 0x44556677; fetch A at addr 0..4 -> instr_A = 0x001122, 0x112233, 0x223344, 0x334455, 0x445566 one cycle later.
REQ-041 we=1 and re_B=1 at addr 2 same cycle -> rdy_B=0 next cycle, valid_B two cycles after request, instr_B=0x223344 (post-write data if that write hit those bytes).
REQ-042 Three consecutive writes with re_B pending -> valid_B only in the cycle after the first write-free cycle; exactly one valid_B pulse.
REQ-043 wr_be=4'b0100 with wr_data=0xFFFFFFFF on row 0 -> row_data_B = 0x0011FF33.
REQ-044 PC_BITWIDTH=16, fetch A at 0xFFFF -> bytes mem[0xFFFF], mem[0x0000], mem[0x0001].
REQ-045 Assert reset_n=0 while PEND -> rdy_B=1, valid_B=0 immediately; no valid_B after release.

Source files
------------

// File: rtl/imem_banked_if.sv
// ---------------------------------------------------------------------------
// imem_banked_if
// Bus bundle for the banked instruction memory.
//   Write side : we, wr_addr (row), wr_data, wr_be (byte enable per bank)
//   Port A     : re_A/addr_A in, valid_A/instr_A out (read-only, never stalls)
//   Port B     : re_B/addr_B in, rdy_B out, valid_B/instr_B/row_data_B out
// Handshake: a port-B request is taken on a rising edge where re_B=1 and
// rdy_B=1. re_B is ignored while rdy_B=0. Every taken request produces exactly
// one valid_B pulse. valid_A/valid_B are single-cycle result strobes with no
// back-pressure. Data outputs hold their last value while valid is low.
// master = the requester (testbench/core), slave = the memory.
// ---------------------------------------------------------------------------
interface imem_banked_if #(
    parameter int PC_BITWIDTH = 16,
    parameter int NUM_BANKS   = 4,
    parameter int FETCH_BYTES = 3
);
    localparam int LB       = $clog2(NUM_BANKS);
    localparam int ROW_BITS = PC_BITWIDTH - LB;
    localparam int FW       = 8 * FETCH_BYTES;
    localparam int WW       = 8 * NUM_BANKS;

    logic                   we;
    logic [ROW_BITS-1:0]    wr_addr;
    logic [WW-1:0]          wr_data;
    logic [NUM_BANKS-1:0]   wr_be;
    logic                   re_A;
    logic [PC_BITWIDTH-1:0] addr_A;
    logic                   re_B;
    logic [PC_BITWIDTH-1:0] addr_B;
    logic                   rdy_B;
    logic                   valid_A;
    logic                   valid_B;
    logic [FW-1:0]          instr_A;
    logic [FW-1:0]          instr_B;
    logic [WW-1:0]          row_data_B;

    modport master (
        output we, wr_addr, wr_data, wr_be, re_A, addr_A, re_B, addr_B,
        input  rdy_B, valid_A, valid_B, instr_A, instr_B, row_data_B
    );

    modport slave (
        input  we, wr_addr, wr_data, wr_be, re_A, addr_A, re_B, addr_B,
        output rdy_B, valid_A, valid_B, instr_A, instr_B, row_data_B
    );
endinterface

// File: rtl/imem_banked.sv
// ---------------------------------------------------------------------------
// imem_banked
// Byte-banked instruction memory returning FETCH_BYTES consecutive bytes from
// any byte alignment with one-cycle latency.
//   clk        : rising-edge clock
//   reset_n    : asynchronous active-low reset (memory contents survive)
//   bus        : imem_banked_if.slave (write port, fetch ports A and B)
//   o_dbg_pend : 1 while the port-B FSM holds a deferred read (state PEND)
// Port A has a dedicated read path. Port B shares its bank port with the
// write path; a B request colliding with a write is parked and issued in
// the first write-free cycle.
// ---------------------------------------------------------------------------
module imem_banked #(
    parameter int PC_BITWIDTH = 16,
    parameter int NUM_BANKS   = 4,
    parameter int FETCH_BYTES = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    imem_banked_if.slave   bus,
    output logic           o_dbg_pend
);
    localparam int LB       = $clog2(NUM_BANKS);
    localparam int ROW_BITS = PC_BITWIDTH - LB;
    localparam int FW       = 8 * FETCH_BYTES;
    localparam int WW       = 8 * NUM_BANKS;
    localparam int DEPTH    = 2 ** ROW_BITS;

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [PC_BITWIDTH-1:0] r_pend_addr;
    logic [PC_BITWIDTH-1:0] w_pend_addr_nxt;
    logic                   w_issue_B;
    logic [PC_BITWIDTH-1:0] w_addr_B;

    logic [7:0]             r_mem [NUM_BANKS][DEPTH];

    logic [ROW_BITS-1:0]    w_row_A;
    logic [ROW_BITS-1:0]    w_row_B;
    logic [LB-1:0]          w_lo_A;
    logic [LB-1:0]          w_lo_B;
    logic [ROW_BITS-1:0]    w_bank_row_A [NUM_BANKS];
    logic [ROW_BITS-1:0]    w_bank_row_B [NUM_BANKS];

    logic [7:0]             r_raw_A [NUM_BANKS];
    logic [7:0]             r_raw_B [NUM_BANKS];
    logic [7:0]             r_row_B [NUM_BANKS];
    logic [LB-1:0]          r_lo_A;
    logic [LB-1:0]          r_lo_B;
    logic                   r_valid_A;
    logic                   r_valid_B;

    logic [FW-1:0]          w_instr_A;
    logic [FW-1:0]          w_instr_B;
    logic [WW-1:0]          w_row_data_B;

    // ---------------- port-B FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_pend_addr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend_addr <= w_pend_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pend_addr_nxt = r_pend_addr;
        w_issue_B       = 1'b0;
        w_addr_B        = bus.addr_B;
        case (r_state)
            IDLE: begin
                if (bus.re_B) begin
                    if (bus.we) begin
                        // Bank port busy with the write: park the address.
                        w_state_nxt     = PEND;
                        w_pend_addr_nxt = bus.addr_B;
                    end else begin
                        w_issue_B = 1'b1;
                    end
                end
            end
            PEND: begin
                if (!bus.we) begin
                    w_issue_B   = 1'b1;
                    w_addr_B    = r_pend_addr;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.rdy_B  = (r_state == IDLE);
    assign o_dbg_pend = (r_state == PEND);

    // ---------------- bank row selection ----------------
    // Banks below the start bank hold bytes that spilled into the next row.
    assign w_row_A = bus.addr_A[PC_BITWIDTH-1:LB];
    assign w_lo_A  = bus.addr_A[LB-1:0];
    assign w_row_B = w_addr_B[PC_BITWIDTH-1:LB];
    assign w_lo_B  = w_addr_B[LB-1:0];

    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            w_bank_row_A[i] = w_row_A + ((LB'(i) < w_lo_A) ? ROW_BITS'(1) : ROW_BITS'(0));
            w_bank_row_B[i] = w_row_B + ((LB'(i) < w_lo_B) ? ROW_BITS'(1) : ROW_BITS'(0));
        end
    end

    // ---------------- storage (not reset) ----------------
    always_ff @(posedge clk) begin
        if (bus.we) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (bus.wr_be[i]) begin
                    r_mem[i][bus.wr_addr] <= bus.wr_data[WW-1-8*i -: 8];
                end
            end
        end
    end

    // ---------------- read registers ----------------
    // Reads sample r_mem before the same-edge write lands, so a colliding
    // read returns the old byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid_A <= 1'b0;
            r_valid_B <= 1'b0;
            r_lo_A    <= '0;
            r_lo_B    <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                r_raw_A[i] <= '0;
                r_raw_B[i] <= '0;
                r_row_B[i] <= '0;
            end
        end else begin
            r_valid_A <= bus.re_A;
            r_valid_B <= w_issue_B;
            if (bus.re_A) begin
                r_lo_A <= w_lo_A;
                for (int i = 0; i < NUM_BANKS; i++) begin
                    r_raw_A[i] <= r_mem[i][w_bank_row_A[i]];
                end
            end
            if (w_issue_B) begin
                r_lo_B <= w_lo_B;
                for (int i = 0; i < NUM_BANKS; i++) begin
                    r_raw_B[i] <= r_mem[i][w_bank_row_B[i]];
                    r_row_B[i] <= r_mem[i][w_row_B];
                end
            end
        end
    end

    // ---------------- output byte rotation ----------------
    // Byte k comes from bank (lo + k) mod NUM_BANKS; the LB-bit sum wraps.
    always_comb begin
        w_instr_A    = '0;
        w_instr_B    = '0;
        w_row_data_B = '0;
        for (int k = 0; k < FETCH_BYTES; k++) begin
            w_instr_A[FW-1-8*k -: 8] = r_raw_A[r_lo_A + LB'(k)];
            w_instr_B[FW-1-8*k -: 8] = r_raw_B[r_lo_B + LB'(k)];
        end
        for (int i = 0; i < NUM_BANKS; i++) begin
            w_row_data_B[WW-1-8*i -: 8] = r_row_B[i];
        end
    end

    assign bus.valid_A    = r_valid_A;
    assign bus.valid_B    = r_valid_B;
    assign bus.instr_A    = w_instr_A;
    assign bus.instr_B    = w_instr_B;
    assign bus.row_data_B = w_row_data_B;
endmodule

// File: tb/tb_imem_banked.sv
// ---------------------------------------------------------------------------
// tb_imem_banked
// Scoreboard bench for imem_banked (PC_BITWIDTH=16, NUM_BANKS=4,
// FETCH_BYTES=3). The driver updates a flat byte-array model of memory and
// pushes expected results with their issue cycle; a negedge monitor pops and
// compares whenever a result is due, and checks hold behaviour otherwise.
// ---------------------------------------------------------------------------
module tb_imem_banked;
    localparam int PCW = 16;
    localparam int NB  = 4;
    localparam int FB  = 3;
    localparam int FW  = 8 * FB;
    localparam int WW  = 8 * NB;
    localparam int RB  = PCW - 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;
    logic dbg_pend;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    imem_banked_if #(.PC_BITWIDTH(PCW), .NUM_BANKS(NB), .FETCH_BYTES(FB)) bus ();

    imem_banked #(.PC_BITWIDTH(PCW), .NUM_BANKS(NB), .FETCH_BYTES(FB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .o_dbg_pend (dbg_pend)
    );

    // ---------------- model and scoreboard ----------------
    logic [7:0]    m_mem [65536];
    bit            m_pend;
    logic [15:0]   m_pend_addr;

    logic [FW-1:0] exp_a_q[$];
    int            exp_a_cyc_q[$];
    logic [FW-1:0] exp_b_q[$];
    logic [WW-1:0] exp_row_q[$];
    int            exp_b_cyc_q[$];
    logic [FW-1:0] last_a;
    logic [FW-1:0] last_b;
    logic [WW-1:0] last_row;

    int n_checks;
    int n_errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] model_fetch(input logic [15:0] a);
        logic [FW-1:0] r;
        logic [15:0]   p;
        r = '0;
        for (int k = 0; k < FB; k++) begin
            p = a + 16'(k);
            r[FW-1-8*k -: 8] = m_mem[p];
        end
        return r;
    endfunction

    function automatic logic [WW-1:0] model_row(input logic [15:0] a);
        logic [WW-1:0] r;
        logic [15:0]   p;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            p = {a[15:2], 2'(i)};
            r[WW-1-8*i -: 8] = m_mem[p];
        end
        return r;
    endfunction

    // ---------------- driver ----------------
    // Called at posedge+1; applies one cycle of stimulus and returns at the
    // next posedge+1. ovr_* replace the model prediction with a fixed value.
    task automatic drive(
        input logic ra, input logic [15:0] aa,
        input logic rb, input logic [15:0] ab,
        input logic w, input logic [RB-1:0] wa, input logic [WW-1:0] wd, input logic [NB-1:0] be,
        input bit ovr_a, input logic [FW-1:0] oa,
        input bit ovr_b, input logic [FW-1:0] ob, input logic [WW-1:0] orow
    );
        logic        issue_b;
        logic [15:0] b_addr;
        logic [15:0] p;
        check("rdy_B", bus.rdy_B, !m_pend);
        check("dbg_pend", dbg_pend, m_pend);
        bus.re_A    = ra;
        bus.addr_A  = aa;
        bus.re_B    = rb;
        bus.addr_B  = ab;
        bus.we      = w;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.wr_be   = be;
        issue_b = 1'b0;
        b_addr  = ab;
        if (!m_pend) begin
            if (rb && !w) issue_b = 1'b1;
            else if (rb && w) begin
                m_pend      = 1'b1;
                m_pend_addr = ab;
            end
        end else if (!w) begin
            issue_b = 1'b1;
            b_addr  = m_pend_addr;
            m_pend  = 1'b0;
        end
        if (ra) begin
            exp_a_q.push_back(ovr_a ? oa : model_fetch(aa));
            exp_a_cyc_q.push_back(cyc);
        end
        if (issue_b) begin
            exp_b_q.push_back(ovr_b ? ob : model_fetch(b_addr));
            exp_row_q.push_back(ovr_b ? orow : model_row(b_addr));
            exp_b_cyc_q.push_back(cyc);
        end
        // Reads above see pre-write contents; the write lands afterwards.
        if (w) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    p = {wa, 2'(i)};
                    m_mem[p] = wd[WW-1-8*i -: 8];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [RB-1:0] wa, input logic [WW-1:0] wd, input logic [NB-1:0] be);
        drive(0, 0, 0, 0, 1, wa, wd, be, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 16'(16'hFFF0 + $urandom_range(0, 15));
        return 16'($urandom_range(0, 255));
    endfunction

    function automatic logic [RB-1:0] rand_row();
        if ($urandom_range(0, 9) == 0) return RB'(16380 + $urandom_range(0, 3));
        return RB'($urandom_range(0, 67));
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            if (exp_a_q.size() > 0 && exp_a_cyc_q[0] + 1 <= cyc) begin
                last_a = exp_a_q.pop_front();
                void'(exp_a_cyc_q.pop_front());
                check("valid_A", bus.valid_A, 1'b1);
                check("instr_A", bus.instr_A, last_a);
            end else begin
                check("valid_A_idle", bus.valid_A, 1'b0);
                check("instr_A_hold", bus.instr_A, last_a);
            end
            if (exp_b_q.size() > 0 && exp_b_cyc_q[0] + 1 <= cyc) begin
                last_b   = exp_b_q.pop_front();
                last_row = exp_row_q.pop_front();
                void'(exp_b_cyc_q.pop_front());
                check("valid_B", bus.valid_B, 1'b1);
                check("instr_B", bus.instr_B, last_b);
                check("row_data_B", bus.row_data_B, last_row);
            end else begin
                check("valid_B_idle", bus.valid_B, 1'b0);
                check("instr_B_hold", bus.instr_B, last_b);
                check("row_data_B_hold", bus.row_data_B, last_row);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        m_pend = 1'b0;
        m_pend_addr = '0;
        last_a = '0;
        last_b = '0;
        last_row = '0;
        reset_n = 1'b0;
        bus.re_A = 0; bus.addr_A = 0; bus.re_B = 0; bus.addr_B = 0;
        bus.we = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.wr_be = 0;

        // Reset state, before any clock edge.
        #3;
        check("rst_rdy_B", bus.rdy_B, 1'b1);
        check("rst_valid_A", bus.valid_A, 1'b0);
        check("rst_valid_B", bus.valid_B, 1'b0);
        check("rst_instr_A", bus.instr_A, '0);
        check("rst_instr_B", bus.instr_B, '0);
        check("rst_row_data_B", bus.row_data_B, '0);
        check("rst_pend", dbg_pend, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Fill the exercised region with random data.
        for (int r = 0; r < 68; r++) wr(RB'(r), WW'($urandom), '1);
        for (int r = 16380; r < 16384; r++) wr(RB'(r), WW'($urandom), '1);

        // Aligned and unaligned fetches across a row boundary.
        wr(0, 32'h00112233, 4'hF);
        wr(1, 32'h44556677, 4'hF);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 24'h001122, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 1, 24'h112233, 0, 0, 0);
        drive(1, 2, 0, 0, 0, 0, 0, 0, 1, 24'h223344, 0, 0, 0);
        drive(1, 3, 0, 0, 0, 0, 0, 0, 1, 24'h334455, 0, 0, 0);
        drive(1, 4, 0, 0, 0, 0, 0, 0, 1, 24'h445566, 0, 0, 0);
        idle();

        // B request colliding with a write: parked one cycle.
        drive(0, 0, 1, 2, 1, 5, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 24'h223344, 32'h00112233);
        idle();

        // Three back-to-back writes keep B parked; one result afterwards.
        drive(0, 0, 1, 4, 1, 10, 32'h01020304, 4'hF, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 8, 1, 11, 32'h05060708, 4'hF, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 12, 1, 12, 32'h090A0B0C, 4'hF, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 24'h445566, 32'h44556677);
        idle();
        idle();

        // Partial byte-enable write.
        wr(0, 32'hFFFFFFFF, 4'b0100);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 24'h0011FF, 32'h0011FF33);
        idle();

        // Fetch wrapping past the top of the address space.
        wr(16383, 32'hAABBCCDD, 4'hF);
        drive(1, 16'hFFFF, 0, 0, 0, 0, 0, 0, 1, 24'hDD0011, 0, 0, 0);
        idle();

        // Same-cycle write and read of the same row: old data, then new.
        drive(1, 8, 1, 9, 1, 2, 32'hA1A2A3A4, 4'hF, 0, 0, 0, 0, 0);
        drive(1, 8, 0, 0, 0, 0, 0, 0, 1, 24'hA1A2A3, 0, 0, 0);
        idle();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            drive(1'($urandom_range(0, 1)), rand_addr(),
                  1'($urandom_range(0, 1)), rand_addr(),
                  1'($urandom_range(0, 9) < 4), rand_row(), WW'($urandom), NB'($urandom),
                  0, 0, 0, 0, 0);
        end
        idle();
        idle();

        // Reset while a B read is parked: it must be dropped.
        drive(0, 0, 1, 20, 1, 30, 32'h12345678, 4'hF, 0, 0, 0, 0, 0);
        check("pend_rdy_B", bus.rdy_B, 1'b0);
        check("pend_dbg", dbg_pend, 1'b1);
        bus.we = 0; bus.re_A = 0; bus.re_B = 0;
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_rdy_B", bus.rdy_B, 1'b1);
        check("midrst_valid_B", bus.valid_B, 1'b0);
        check("midrst_instr_B", bus.instr_B, '0);
        check("midrst_row_data_B", bus.row_data_B, '0);
        check("midrst_pend", dbg_pend, 1'b0);
        m_pend = 1'b0;
        last_a = '0;
        last_b = '0;
        last_row = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle();
        idle();
        idle();

        // Memory survives reset; more random traffic.
        for (int n = 0; n < 200; n++) begin
            drive(1'($urandom_range(0, 1)), rand_addr(),
                  1'($urandom_range(0, 1)), rand_addr(),
                  1'($urandom_range(0, 9) < 4), rand_row(), WW'($urandom), NB'($urandom),
                  0, 0, 0, 0, 0);
        end
        for (int n = 0; n < 4; n++) idle();

        check("exp_a_q_drained", 64'(exp_a_q.size()), 0);
        check("exp_b_q_drained", 64'(exp_b_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
